conv_array_ctrl: RTL

//  Sequencer for the 3x5 row-stationary PE array computing one 7x7 (*) 3x3 -> 5x5 convolution.

---
 rtl/conv_array_ctrl.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/conv_array_ctrl.sv
// conv_array_ctrl
// ---------------
// Sequencer for a 3x5 row-stationary PE array that computes one 7x7 (*) 3x3 -> 5x5
// convolution. A run has three working phases:
//   LOAD : stream the filter words, then the ifmap words, from the ROM into the PE
//          scratchpads. The ROM returns data one cycle after rom_rd, so the scratchpad
//          write strobe and its row/column tags are a one-cycle-delayed copy of the read.
//   COMP : step the PE array through every (output column, filter tap) pair. The
//          vertical psum accumulation is combinational inside the array, so this
//          phase needs no drain cycles.
//   WB   : stream the DO_W*DO_H results to the DRAM-side writer.
// The run finishes with a one-cycle DONE state that pulses done.
//
// Result handshake: a beat transfers on a rising edge where out_valid && out_ready.
// out_valid stays high for the whole WB phase and does not depend on out_ready.
// out_addr changes only after its beat has transferred, so it is stable while
// out_ready is low.
//
// Ports
//   clk, rst_n               clock (rising edge); asynchronous active-low reset
//   start                    begin a run; sampled in IDLE only
//   abort                    synchronous cancel from any non-IDLE state; beats start
//   busy, done               busy in LOAD/COMP/WB; done is a pulse in the DONE state
//   rom_rd, rom_addr         ROM read strobe and word address
//   spad_we/kind/row/col     scratchpad write (kind 0 = filter, 1 = ifmap)
//   pe_en/clr/tap/col        PE array MAC enable, psum clear, filter tap, output column
//   out_valid/ready/addr     result stream, out_addr = row*DO_W + col
module conv_array_ctrl #(
  parameter int DI_W   = 7,
  parameter int DI_H   = 7,
  parameter int FIL_S  = 3,
  parameter int DO_W   = DI_W - FIL_S + 1,
  parameter int DO_H   = DI_H - FIL_S + 1,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              spad_we,
  output logic              spad_kind,
  output logic [2:0]        spad_row,
  output logic [2:0]        spad_col,
  output logic              pe_en,
  output logic              pe_clr,
  output logic [1:0]        pe_tap,
  output logic [2:0]        pe_col,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_COMP = 3'd2,
    S_WB   = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // Number of ROM words per run; LOAD lasts N_RD+1 cycles (last cycle writes only).
  localparam logic [ADDR_W-1:0] N_RD      = ADDR_W'(FIL_S*FIL_S + DI_W*DI_H);
  localparam logic [ADDR_W-1:0] RD_LAST   = ADDR_W'(FIL_S*FIL_S + DI_W*DI_H - 1);
  localparam logic [ADDR_W-1:0] RES_LAST  = ADDR_W'(DO_W*DO_H - 1);
  localparam logic [2:0]        FIL_LAST  = 3'(FIL_S - 1);
  localparam logic [2:0]        DI_LAST   = 3'(DI_W - 1);
  localparam logic [1:0]        TAP_LAST  = 2'(FIL_S - 1);
  localparam logic [2:0]        OCOL_LAST = 3'(DO_W - 1);

  state_e state_q, state_d;

  // LOAD bookkeeping: cycle count plus the row/column tag of the word being read.
  logic [ADDR_W-1:0] ld_cnt_q, ld_cnt_d;
  logic              rd_kind_q, rd_kind_d;
  logic [2:0]        rd_row_q, rd_row_d;
  logic [2:0]        rd_col_q, rd_col_d;

  // Scratchpad write stage: the read tag delayed by the ROM latency.
  logic              sp_we_q, sp_we_d;
  logic              sp_kind_q, sp_kind_d;
  logic [2:0]        sp_row_q, sp_row_d;
  logic [2:0]        sp_col_q, sp_col_d;

  // COMP position and WB result address.
  logic [1:0]        tap_q, tap_d;
  logic [2:0]        pcol_q, pcol_d;
  logic [ADDR_W-1:0] oaddr_q, oaddr_d;

  logic rd_active;
  logic load_last;
  logic comp_last;
  logic wb_fire;
  logic wb_last;

  assign rd_active = (state_q == S_LOAD) && (ld_cnt_q < N_RD);
  assign load_last = (state_q == S_LOAD) && (ld_cnt_q == N_RD);
  assign comp_last = (state_q == S_COMP) && (tap_q == TAP_LAST) && (pcol_q == OCOL_LAST);
  assign wb_fire   = (state_q == S_WB) && out_ready;
  assign wb_last   = wb_fire && (oaddr_q == RES_LAST);

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start)     state_d = S_LOAD;
        S_LOAD:  if (load_last) state_d = S_COMP;
        S_COMP:  if (comp_last) state_d = S_WB;
        S_WB:    if (wb_last)   state_d = S_DONE;
        S_DONE:                 state_d = S_IDLE;
        default:                state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- datapath counters
  always_comb begin
    ld_cnt_d  = ld_cnt_q;
    rd_kind_d = rd_kind_q;
    rd_row_d  = rd_row_q;
    rd_col_d  = rd_col_q;
    sp_we_d   = rd_active;
    sp_kind_d = rd_kind_q;
    sp_row_d  = rd_row_q;
    sp_col_d  = rd_col_q;
    tap_d     = tap_q;
    pcol_d    = pcol_q;
    oaddr_d   = oaddr_q;

    if ((state_q == S_IDLE) || abort) begin
      // Every run starts from zeroed counters; an abort discards partial progress.
      ld_cnt_d  = '0;
      rd_kind_d = 1'b0;
      rd_row_d  = '0;
      rd_col_d  = '0;
      sp_we_d   = 1'b0;
      sp_kind_d = 1'b0;
      sp_row_d  = '0;
      sp_col_d  = '0;
      tap_d     = '0;
      pcol_d    = '0;
      oaddr_d   = '0;
    end else begin
      if (state_q == S_LOAD && ld_cnt_q < N_RD) begin
        ld_cnt_d = ld_cnt_q + ADDR_W'(1);
      end
      // Walk the read tag row-major: filter rows first, then ifmap rows.
      // The tag is frozen on the final read so the row never steps past its range.
      if (rd_active && (ld_cnt_q != RD_LAST)) begin
        if (!rd_kind_q) begin
          if (rd_col_q == FIL_LAST) begin
            rd_col_d = '0;
            if (rd_row_q == FIL_LAST) begin
              rd_row_d  = '0;
              rd_kind_d = 1'b1;
            end else begin
              rd_row_d = rd_row_q + 3'd1;
            end
          end else begin
            rd_col_d = rd_col_q + 3'd1;
          end
        end else begin
          if (rd_col_q == DI_LAST) begin
            rd_col_d = '0;
            rd_row_d = rd_row_q + 3'd1;
          end else begin
            rd_col_d = rd_col_q + 3'd1;
          end
        end
      end

      // Tap is the fast index; the output column advances when the tap wraps.
      if (state_q == S_COMP) begin
        if (tap_q == TAP_LAST) begin
          tap_d = '0;
          if (pcol_q != OCOL_LAST) pcol_d = pcol_q + 3'd1;
        end else begin
          tap_d = tap_q + 2'd1;
        end
      end

      if (wb_fire && !wb_last) begin
        oaddr_d = oaddr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt_q  <= '0;
      rd_kind_q <= 1'b0;
      rd_row_q  <= '0;
      rd_col_q  <= '0;
      sp_we_q   <= 1'b0;
      sp_kind_q <= 1'b0;
      sp_row_q  <= '0;
      sp_col_q  <= '0;
      tap_q     <= '0;
      pcol_q    <= '0;
      oaddr_q   <= '0;
    end else begin
      ld_cnt_q  <= ld_cnt_d;
      rd_kind_q <= rd_kind_d;
      rd_row_q  <= rd_row_d;
      rd_col_q  <= rd_col_d;
      sp_we_q   <= sp_we_d;
      sp_kind_q <= sp_kind_d;
      sp_row_q  <= sp_row_d;
      sp_col_q  <= sp_col_d;
      tap_q     <= tap_d;
      pcol_q    <= pcol_d;
      oaddr_q   <= oaddr_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  // Outputs decode registered state only, so every output is 0 outside its phase.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    rom_rd    = 1'b0;
    rom_addr  = '0;
    spad_we   = 1'b0;
    spad_kind = 1'b0;
    spad_row  = '0;
    spad_col  = '0;
    pe_en     = 1'b0;
    pe_clr    = 1'b0;
    pe_tap    = '0;
    pe_col    = '0;
    out_valid = 1'b0;
    out_addr  = '0;
    case (state_q)
      S_LOAD: begin
        busy     = 1'b1;
        rom_rd   = rd_active;
        rom_addr = rd_active ? ld_cnt_q : '0;
        spad_we  = sp_we_q;
        if (sp_we_q) begin
          spad_kind = sp_kind_q;
          spad_row  = sp_row_q;
          spad_col  = sp_col_q;
        end
      end
      S_COMP: begin
        busy   = 1'b1;
        pe_en  = 1'b1;
        pe_clr = (tap_q == 2'd0) && (pcol_q == 3'd0);
        pe_tap = tap_q;
        pe_col = pcol_q;
      end
      S_WB: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_addr  = oaddr_q;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
